// File: rtl/barrel_pkg.sv
// Shared types and helpers for the barrel rotate sequencer.
package barrel_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} seq_state_e;

  // Reduces a rotate amount into the range 0..n-1.
  function automatic int unsigned mod_amount(input int unsigned amount, input int unsigned n);
    return amount % n;
  endfunction

endpackage

// File: rtl/barrel_rotate_sequencer_sva.sv
// Simulation-only properties for the barrel rotate sequencer, attached by bind.
module barrel_rotate_sequencer_sva #(
  parameter int N        = 8,
  parameter int MAX_REPS = 16,
  parameter int RW       = $clog2(MAX_REPS + 1)
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          cmd_valid_i,
  input logic          cmd_ready_o,
  input logic [RW-1:0] cmd_reps_i,
  input logic          res_valid_o,
  input logic          res_ready_i,
  input logic [N-1:0]  res_data_o
);

  // An accepted command must not ask for more beats than the block supports.
  reps_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cmd_valid_i && cmd_ready_o) |-> (cmd_reps_i <= RW'(MAX_REPS)));

  // A stalled beat stays valid and unchanged.
  stall_holds: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (res_valid_o && !res_ready_i) |=> (res_valid_o && $stable(res_data_o)));

endmodule

bind barrel_rotate_sequencer barrel_rotate_sequencer_sva #(
  .N(N), .MAX_REPS(MAX_REPS), .RW(RW)
) u_sva (
  .clk_i       (clk_i),
  .rst_ni      (rst_ni),
  .cmd_valid_i (cmd_valid_i),
  .cmd_ready_o (cmd_ready_o),
  .cmd_reps_i  (cmd_reps_i),
  .res_valid_o (res_valid_o),
  .res_ready_i (res_ready_i),
  .res_data_o  (res_data_o)
);

// File: rtl/parameterized_barrel_shifter.sv
// Purely combinational N-bit rotator; amount is already reduced below N.
module parameterized_barrel_shifter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         data_i,
  input  logic [$clog2(N)-1:0] amount_i,
  input  logic                 dir_i,
  output logic [N-1:0]         data_o
);

  logic [2*N-1:0] doubled_s;
  logic [2*N-1:0] shifted_s;

  // Rotate by shifting a doubled copy of the word and keeping the wrapped half.
  always_comb begin
    doubled_s = {data_i, data_i};
    if (dir_i) begin
      shifted_s = doubled_s << amount_i;
      data_o    = shifted_s[2*N-1:N];
    end else begin
      shifted_s = doubled_s >> amount_i;
      data_o    = shifted_s[N-1:0];
    end
  end

endmodule

// File: rtl/barrel_rotate_sequencer.sv
// Turns one rotate command into a stream of successively rotated result beats.
module barrel_rotate_sequencer
  import barrel_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_REPS = 16,
  parameter int RW       = $clog2(MAX_REPS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [N-1:0]         cmd_data_i,
  input  logic [$clog2(N):0]   cmd_amount_i,
  input  logic                 cmd_dir_i,
  input  logic [RW-1:0]        cmd_reps_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [N-1:0]         res_data_o,
  output logic [RW-1:0]        res_index_o,
  output logic                 res_last_o,
  output logic                 busy_o
);

  localparam int SW = $clog2(N);

  seq_state_e    state_r;
  logic [N-1:0]  res_data_r;
  logic [RW-1:0] res_index_r;
  logic          res_valid_r;
  logic          res_last_r;
  logic [RW-1:0] reps_r;
  logic          dir_r;
  logic [SW-1:0] amount_r;

  logic [RW-1:0] reps_clamped_s;
  logic [SW-1:0] cmd_amount_mod_s;
  logic [N-1:0]  sh_data_s;
  logic [SW-1:0] sh_amount_s;
  logic          sh_dir_s;
  logic [N-1:0]  sh_out_s;

  assign cmd_ready_o = (state_r == IDLE);
  assign busy_o      = (state_r == RUN);
  assign res_valid_o = res_valid_r;
  assign res_data_o  = res_data_r;
  assign res_index_o = res_index_r;
  assign res_last_o  = res_last_r;

  // Clamp the repeat count and reduce the incoming amount modulo N.
  always_comb begin
    if (cmd_reps_i > RW'(MAX_REPS)) begin
      reps_clamped_s = RW'(MAX_REPS);
    end else begin
      reps_clamped_s = cmd_reps_i;
    end
    cmd_amount_mod_s = SW'(mod_amount(int'(unsigned'(cmd_amount_i)), N));
  end

  // Shifter feeds from the command in IDLE and from the last beat in RUN.
  always_comb begin
    sh_data_s   = cmd_data_i;
    sh_amount_s = '0;
    sh_dir_s    = cmd_dir_i;
    if (state_r == IDLE) begin
      sh_data_s   = cmd_data_i;
      sh_dir_s    = cmd_dir_i;
      sh_amount_s = (cmd_reps_i == RW'(0)) ? SW'(0) : cmd_amount_mod_s;
    end else begin
      sh_data_s   = res_data_r;
      sh_dir_s    = dir_r;
      sh_amount_s = amount_r;
    end
  end

  parameterized_barrel_shifter #(.N(N)) u_shifter (
    .data_i   (sh_data_s),
    .amount_i (sh_amount_s),
    .dir_i    (sh_dir_s),
    .data_o   (sh_out_s)
  );

  // Command/beat sequencing FSM with registered result stream.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_index_r <= '0;
      res_last_r  <= 1'b0;
      reps_r      <= '0;
      dir_r       <= 1'b0;
      amount_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid_i) begin
            res_data_r  <= sh_out_s;
            res_valid_r <= 1'b1;
            res_index_r <= (reps_clamped_s == RW'(0)) ? RW'(0) : RW'(1);
            res_last_r  <= (reps_clamped_s <= RW'(1));
            reps_r      <= reps_clamped_s;
            dir_r       <= cmd_dir_i;
            amount_r    <= cmd_amount_mod_s;
            state_r     <= RUN;
          end
        end
        RUN: begin
          if (res_valid_r && res_ready_i) begin
            if (res_last_r) begin
              res_valid_r <= 1'b0;
              state_r     <= IDLE;
            end else begin
              res_data_r  <= sh_out_s;
              res_index_r <= res_index_r + RW'(1);
              res_last_r  <= ((res_index_r + RW'(1)) == reps_r);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_rotate_sequencer.sv
// Directed self-checking bench for barrel_rotate_sequencer (N=8, MAX_REPS=16).
module tb_barrel_rotate_sequencer;

  localparam int N  = 8;
  localparam int RW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [N-1:0]  cmd_data_i;
  logic [3:0]    cmd_amount_i;
  logic          cmd_dir_i;
  logic [RW-1:0] cmd_reps_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [N-1:0]  res_data_o;
  logic [RW-1:0] res_index_o;
  logic          res_last_o;
  logic          busy_o;

  int tests  = 0;
  int failed = 0;

  // Beat capture shared by the collection task and the tests.
  logic [N-1:0]  beat_d [0:31];
  logic [RW-1:0] beat_i [0:31];
  logic          beat_l [0:31];
  int            n_beats;
  bit            timed_out;
  bit            stall_bad;
  int            stall_cnt;
  logic          ready_at_last;

  barrel_rotate_sequencer #(.N(8), .MAX_REPS(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_data_i   (cmd_data_i),
    .cmd_amount_i (cmd_amount_i),
    .cmd_dir_i    (cmd_dir_i),
    .cmd_reps_i   (cmd_reps_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_index_o  (res_index_o),
    .res_last_o   (res_last_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one command for a single cycle once the block is ready.
  task automatic run_cmd(input logic [7:0] d, input logic [3:0] a, input logic dir, input logic [4:0] r);
    for (int w = 0; w < 50 && !cmd_ready_o; w++) @(negedge clk_i);
    cmd_data_i   = d;
    cmd_amount_i = a;
    cmd_dir_i    = dir;
    cmd_reps_i   = r;
    cmd_valid_i  = 1'b1;
    @(negedge clk_i);
    cmd_valid_i  = 1'b0;
    cmd_data_i   = 8'hFF;
  endtask

  // Record beats until the last one; optionally stall before beat index stall_at.
  task automatic collect(input int stall_at, input int stall_len);
    logic [N-1:0]  hd;
    logic [RW-1:0] hi;
    logic          hl;
    bit done;
    n_beats = 0; timed_out = 1'b0; stall_bad = 1'b0; stall_cnt = 0; done = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (res_valid_o) begin
        if (n_beats == stall_at && stall_cnt < stall_len) begin
          res_ready_i = 1'b0;
          if (stall_cnt == 0) begin
            hd = res_data_o; hi = res_index_o; hl = res_last_o;
          end else if (res_data_o !== hd || res_index_o !== hi || res_last_o !== hl) begin
            stall_bad = 1'b1;
          end
          stall_cnt++;
        end else begin
          if (stall_cnt > 0 && n_beats == stall_at &&
              (res_data_o !== hd || res_index_o !== hi || res_last_o !== hl)) stall_bad = 1'b1;
          res_ready_i      = 1'b1;
          beat_d[n_beats]  = res_data_o;
          beat_i[n_beats]  = res_index_o;
          beat_l[n_beats]  = res_last_o;
          n_beats++;
          if (res_last_o) begin
            done = 1'b1;
            ready_at_last = cmd_ready_o;
          end
        end
      end else begin
        if (n_beats == stall_at && stall_cnt > 0 && stall_cnt < stall_len) stall_bad = 1'b1;
        res_ready_i = 1'b1;
      end
      @(negedge clk_i);
    end
    res_ready_i = 1'b1;
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    tests++;
    if (res_valid_o !== 1'b0 || res_data_o !== 8'h00 || res_index_o !== 5'd0 ||
        res_last_o !== 1'b0 || busy_o !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: got v=%b d=%h i=%0d l=%b busy=%b, expected all zero",
               res_valid_o, res_data_o, res_index_o, res_last_o, busy_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (cmd_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready: got %b, expected 1", cmd_ready_o);
    end
  endtask

  task automatic test_rotate_left();
    logic [7:0] exp_d [3];
    exp_d = '{8'h03, 8'h06, 8'h0C};
    run_cmd(8'h81, 4'd1, 1'b1, 5'd3);
    collect(99, 0);
    tests++;
    if (n_beats !== 3 || timed_out) begin
      failed++;
      $display("FAIL rotl_count: got %0d beats (timeout=%0d), expected 3", n_beats, timed_out);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (beat_d[i] !== exp_d[i] || beat_i[i] !== 5'(i + 1) || beat_l[i] !== 1'(i == 2)) begin
        failed++;
        $display("FAIL rotl_beat%0d: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                 i + 1, beat_d[i], beat_i[i], beat_l[i], exp_d[i], i + 1, (i == 2));
      end
    end
  endtask

  task automatic test_rotate_right_bubble();
    logic [7:0] exp_d [2];
    exp_d = '{8'hC0, 8'h60};
    run_cmd(8'h81, 4'd1, 1'b0, 5'd2);
    collect(99, 0);
    tests++;
    if (n_beats !== 2 || timed_out) begin
      failed++;
      $display("FAIL rotr_count: got %0d beats (timeout=%0d), expected 2", n_beats, timed_out);
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (beat_d[i] !== exp_d[i] || beat_i[i] !== 5'(i + 1) || beat_l[i] !== 1'(i == 1)) begin
        failed++;
        $display("FAIL rotr_beat%0d: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                 i + 1, beat_d[i], beat_i[i], beat_l[i], exp_d[i], i + 1, (i == 1));
      end
    end
    tests++;
    if (ready_at_last !== 1'b0 || cmd_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL rotr_bubble: got ready_at_last=%b ready_after=%b valid_after=%b, expected 0 1 0",
               ready_at_last, cmd_ready_o, res_valid_o);
    end
  endtask

  task automatic test_amount_wrap();
    run_cmd(8'hA5, 4'd9, 1'b1, 5'd1);
    collect(99, 0);
    tests++;
    if (n_beats !== 1 || timed_out || beat_d[0] !== 8'h4B || beat_i[0] !== 5'd1 || beat_l[0] !== 1'b1) begin
      failed++;
      $display("FAIL wrap_amt9: got n=%0d d=%h i=%0d l=%b, expected n=1 d=4b i=1 l=1",
               n_beats, beat_d[0], beat_i[0], beat_l[0]);
    end
    run_cmd(8'hA5, 4'd8, 1'b1, 5'd1);
    collect(99, 0);
    tests++;
    if (n_beats !== 1 || timed_out || beat_d[0] !== 8'hA5 || beat_l[0] !== 1'b1) begin
      failed++;
      $display("FAIL wrap_amt8: got n=%0d d=%h l=%b, expected n=1 d=a5 l=1",
               n_beats, beat_d[0], beat_l[0]);
    end
  endtask

  task automatic test_reps_zero();
    run_cmd(8'h3C, 4'd3, 1'b1, 5'd0);
    collect(99, 0);
    tests++;
    if (n_beats !== 1 || timed_out || beat_d[0] !== 8'h3C || beat_i[0] !== 5'd0 || beat_l[0] !== 1'b1) begin
      failed++;
      $display("FAIL reps_zero: got n=%0d d=%h i=%0d l=%b, expected n=1 d=3c i=0 l=1",
               n_beats, beat_d[0], beat_i[0], beat_l[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4];
    exp_d = '{8'h0C, 8'h60, 8'h03, 8'h18};
    run_cmd(8'h81, 4'd3, 1'b1, 5'd4);
    collect(1, 5);
    tests++;
    if (n_beats !== 4 || timed_out) begin
      failed++;
      $display("FAIL stall_count: got %0d beats (timeout=%0d), expected 4", n_beats, timed_out);
    end
    tests++;
    if (stall_bad || stall_cnt !== 5) begin
      failed++;
      $display("FAIL stall_hold: got unstable=%0d stall_cycles=%0d, expected 0 and 5", stall_bad, stall_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (beat_d[i] !== exp_d[i] || beat_i[i] !== 5'(i + 1) || beat_l[i] !== 1'(i == 3) ||
          $countones(beat_d[i]) != 2) begin
        failed++;
        $display("FAIL stall_beat%0d: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                 i + 1, beat_d[i], beat_i[i], beat_l[i], exp_d[i], i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    run_cmd(8'h81, 4'd1, 1'b1, 5'd4);
    tests++;
    if (res_valid_o !== 1'b1 || res_data_o !== 8'h03) begin
      failed++;
      $display("FAIL midrst_beat1: got v=%b d=%h, expected v=1 d=03", res_valid_o, res_data_o);
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    tests++;
    if (res_valid_o !== 1'b0 || res_data_o !== 8'h00 || res_index_o !== 5'd0 ||
        res_last_o !== 1'b0 || busy_o !== 1'b0) begin
      failed++;
      $display("FAIL midrst_clear: got v=%b d=%h i=%0d l=%b busy=%b, expected all zero",
               res_valid_o, res_data_o, res_index_o, res_last_o, busy_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (cmd_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL midrst_release: got ready=%b valid=%b, expected 1 0", cmd_ready_o, res_valid_o);
    end
    run_cmd(8'h81, 4'd2, 1'b1, 5'd2);
    collect(99, 0);
    tests++;
    if (n_beats !== 2 || timed_out || beat_d[0] !== 8'h06 || beat_d[1] !== 8'h18 ||
        beat_i[1] !== 5'd2 || beat_l[1] !== 1'b1) begin
      failed++;
      $display("FAIL midrst_fresh: got n=%0d d=%h,%h i2=%0d l2=%b, expected n=2 d=06,18 i2=2 l2=1",
               n_beats, beat_d[0], beat_d[1], beat_i[1], beat_l[1]);
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_data_i   = 8'h00;
    cmd_amount_i = 4'd0;
    cmd_dir_i    = 1'b0;
    cmd_reps_i   = 5'd0;
    res_ready_i  = 1'b1;
    ready_at_last = 1'b0;
    repeat (3) @(negedge clk_i);
    test_reset();
    test_rotate_left();
    test_rotate_right_bubble();
    test_amount_wrap();
    test_reps_zero();
    test_backpressure();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
